// File: rtl/sync_fifo_ram_ctrl.sv
// rtl/sync_fifo_ram_ctrl.sv - FWFT FIFO controller around an external 1rw1rw RAM
//
// Purpose: single-clock FIFO control. RAM port A is write-only and port B is
// read-only. A 2-entry output buffer hides the RAM's 1-cycle registered read,
// which gives the consumer a first-word-fall-through valid/pop interface.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_en, wr_data          push request and data
//   full, wr_overflow       RAM occupancy at capacity; pulse for a dropped push
//   rd_en                   pop the head entry
//   rd_data, rd_valid       head entry and its presence (FWFT)
//   rd_underflow            pulse for a pop request while empty
//   count                   entries held: RAM + in-flight read + output buffer
//   ram_addra/dina/wena     RAM port A write side
//   ram_rena                port A read enable, tied low
//   ram_addrb/renb          RAM port B read side
//   ram_dinb, ram_wenb      port B write side, tied low
//   ram_doutb               RAM read data, valid the cycle after ram_renb
module sync_fifo_ram_ctrl #(
    parameter int WIDTH_ADDR = 8,
    parameter int WIDTH_DATA = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH_DATA-1:0]   wr_data,
    output logic                    full,
    output logic                    wr_overflow,
    input  logic                    rd_en,
    output logic [WIDTH_DATA-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_underflow,
    output logic [WIDTH_ADDR+1:0]   count,
    output logic [WIDTH_ADDR-1:0]   ram_addra,
    output logic [WIDTH_DATA-1:0]   ram_dina,
    output logic                    ram_wena,
    output logic                    ram_rena,
    output logic [WIDTH_ADDR-1:0]   ram_addrb,
    output logic [WIDTH_DATA-1:0]   ram_dinb,
    output logic                    ram_wenb,
    output logic                    ram_renb,
    input  logic [WIDTH_DATA-1:0]   ram_doutb
);

    localparam logic [WIDTH_ADDR:0] DEPTH = {1'b1, {WIDTH_ADDR{1'b0}}};

    logic [WIDTH_ADDR-1:0] wptr;
    logic [WIDTH_ADDR-1:0] rptr;
    logic [WIDTH_ADDR:0]   ram_cnt;
    logic                  inflight;
    logic [WIDTH_DATA-1:0] obuf0;
    logic [WIDTH_DATA-1:0] obuf1;
    logic [1:0]            out_cnt;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            out_occ;
    logic [WIDTH_DATA-1:0] obuf0_nxt;
    logic [WIDTH_DATA-1:0] obuf1_nxt;
    logic [WIDTH_ADDR:0]   ram_cnt_nxt;

    // full looks only at the RAM: a pop frees the output buffer, not a RAM slot.
    assign full     = (ram_cnt == DEPTH);
    assign push     = wr_en & ~full;
    assign rd_valid = (out_cnt != 2'd0);
    assign pop      = rd_en & rd_valid;

    // Output-buffer occupancy after this cycle's capture and pop; a new read is
    // issued only if its data will have a free slot when it returns.
    assign out_occ = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = (ram_cnt != '0) & (out_occ < 3'd2);

    assign ram_wena  = push;
    assign ram_addra = wptr;
    assign ram_dina  = wr_data;
    assign ram_rena  = 1'b0;
    assign ram_renb  = issue;
    assign ram_addrb = rptr;
    assign ram_dinb  = '0;
    assign ram_wenb  = 1'b0;

    assign rd_data = obuf0;
    assign count   = {1'b0, ram_cnt}
                   + {{(WIDTH_ADDR+1){1'b0}}, inflight}
                   + {{WIDTH_ADDR{1'b0}}, out_cnt};

    assign ram_cnt_nxt = ram_cnt
                       + {{WIDTH_ADDR{1'b0}}, push}
                       - {{WIDTH_ADDR{1'b0}}, issue};

    // Shift on pop first, then land returning RAM data behind any survivor.
    always_comb begin
        obuf0_nxt = pop ? obuf1 : obuf0;
        obuf1_nxt = obuf1;
        if (inflight) begin
            if ((out_cnt == 2'd2) || ((out_cnt == 2'd1) && !pop)) begin
                obuf1_nxt = ram_doutb;
            end else begin
                obuf0_nxt = ram_doutb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            ram_cnt      <= '0;
            inflight     <= 1'b0;
            obuf0        <= '0;
            obuf1        <= '0;
            out_cnt      <= 2'd0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr <= rptr + 1'b1;
            end
            ram_cnt      <= ram_cnt_nxt;
            inflight     <= issue;
            obuf0        <= obuf0_nxt;
            obuf1        <= obuf1_nxt;
            out_cnt      <= out_occ[1:0];
            wr_overflow  <= wr_en & full;
            rd_underflow <= rd_en & ~rd_valid;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ram_ctrl.sv
// tb/tb_sync_fifo_ram_ctrl.sv - self-checking bench for sync_fifo_ram_ctrl
module tb_sync_fifo_ram_ctrl;

    localparam int WA    = 4;
    localparam int WD    = 8;
    localparam int DEPTH = 1 << WA;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [WD-1:0] wr_data = '0;
    logic          full;
    logic          wr_overflow;
    logic          rd_en = 1'b0;
    logic [WD-1:0] rd_data;
    logic          rd_valid;
    logic          rd_underflow;
    logic [WA+1:0] count;
    logic [WA-1:0] ram_addra;
    logic [WD-1:0] ram_dina;
    logic          ram_wena;
    logic          ram_rena;
    logic [WA-1:0] ram_addrb;
    logic [WD-1:0] ram_dinb;
    logic          ram_wenb;
    logic          ram_renb;
    logic [WD-1:0] ram_doutb = '0;

    always #5 clk = ~clk;

    sync_fifo_ram_ctrl #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .wr_overflow  (wr_overflow),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_underflow (rd_underflow),
        .count        (count),
        .ram_addra    (ram_addra),
        .ram_dina     (ram_dina),
        .ram_wena     (ram_wena),
        .ram_rena     (ram_rena),
        .ram_addrb    (ram_addrb),
        .ram_dinb     (ram_dinb),
        .ram_wenb     (ram_wenb),
        .ram_renb     (ram_renb),
        .ram_doutb    (ram_doutb)
    );

    // External RAM: port A write, port B registered read (no output register).
    logic [WD-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wena) mem[ram_addra] <= ram_dina;
        if (ram_renb) ram_doutb <= mem[ram_addrb];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: values queued in RAM, one optional read in flight,
    // up to two values visible to the consumer.
    logic [WD-1:0] m_ram[$];
    logic [WD-1:0] m_out[$];
    bit            m_infl;
    logic [WD-1:0] m_infl_d;
    bit            m_ovf;
    bit            m_udf;
    int            m_wp;
    int            m_rp;

    // Values actually popped from the DUT, in order.
    logic [WD-1:0] popped[$];

    // Samples of DUT outputs taken in the most recent step.
    logic          s_full, s_valid, s_ovf, s_udf, s_wena, s_renb;
    logic [WD-1:0] s_data;
    logic [WA-1:0] s_addrb;
    logic [WA+1:0] s_count;

    task automatic model_reset();
        m_ram.delete();
        m_out.delete();
        m_infl   = 1'b0;
        m_infl_d = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_wp     = 0;
        m_rp     = 0;
    endtask

    task automatic step(input bit wr, input logic [WD-1:0] wd, input bit rd);
        bit full_e, valid_e, pop_e, push_e, issue_e;
        int cnt_e;
        @(negedge clk);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        #1;
        full_e  = (m_ram.size() == DEPTH);
        valid_e = (m_out.size() != 0);
        pop_e   = rd && valid_e;
        push_e  = wr && !full_e;
        issue_e = (m_ram.size() != 0) && ((m_out.size() + int'(m_infl) - int'(pop_e)) < 2);
        cnt_e   = m_ram.size() + int'(m_infl) + m_out.size();
        chk("full", 32'(full), 32'(full_e));
        chk("rd_valid", 32'(rd_valid), 32'(valid_e));
        if (valid_e) chk("rd_data", 32'(rd_data), 32'(m_out[0]));
        chk("count", 32'(count), 32'(cnt_e));
        chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
        chk("rd_underflow", 32'(rd_underflow), 32'(m_udf));
        chk("ram_wena", 32'(ram_wena), 32'(push_e));
        chk("ram_renb", 32'(ram_renb), 32'(issue_e));
        if (push_e) begin
            chk("ram_addra", 32'(ram_addra), 32'(m_wp % DEPTH));
            chk("ram_dina", 32'(ram_dina), 32'(wd));
        end
        if (issue_e) chk("ram_addrb", 32'(ram_addrb), 32'(m_rp % DEPTH));
        if (ram_wena && ram_renb) chk("port_collision", 32'(ram_addra == ram_addrb), 32'd0);
        s_full  = full;
        s_valid = rd_valid;
        s_data  = rd_data;
        s_count = count;
        s_ovf   = wr_overflow;
        s_udf   = rd_underflow;
        s_wena  = ram_wena;
        s_renb  = ram_renb;
        s_addrb = ram_addrb;
        if (rd_en && rd_valid) popped.push_back(rd_data);
        @(posedge clk);
        if (pop_e) void'(m_out.pop_front());
        if (m_infl) m_out.push_back(m_infl_d);
        m_infl = issue_e;
        if (issue_e) m_infl_d = m_ram.pop_front();
        if (push_e) m_ram.push_back(wd);
        m_ovf = wr && full_e;
        m_udf = rd && !valid_e;
        if (push_e) m_wp++;
        if (issue_e) m_rp++;
    endtask

    // Reset lands asynchronously, mid-cycle; outputs are checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ram_wena", 32'(ram_wena), 32'd0);
        chk("rst_ram_renb", 32'(ram_renb), 32'd0);
        chk("rst_wr_overflow", 32'(wr_overflow), 32'd0);
        chk("rst_rd_underflow", 32'(rd_underflow), 32'd0);
        chk("tie_ram_rena", 32'(ram_rena), 32'd0);
        chk("tie_ram_wenb", 32'(ram_wenb), 32'd0);
        chk("tie_ram_dinb", 32'(ram_dinb), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pct_wr, pct_rd;
        logic [WD-1:0] exp_v;
        bit ok;

        model_reset();
        do_reset();

        // Single-entry latency.
        step(1'b1, 8'hA5, 1'b0);
        chk("lat_c0_wena", 32'(s_wena), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("lat_c1_renb", 32'(s_renb), 32'd1);
        chk("lat_c1_addrb", 32'(s_addrb), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("lat_c2_valid", 32'(s_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("lat_c3_valid", 32'(s_valid), 32'd1);
        chk("lat_c3_data", 32'(s_data), 32'hA5);
        step(1'b0, 8'h00, 1'b0);
        chk("lat_after_pop_valid", 32'(s_valid), 32'd0);
        chk("lat_after_pop_count", 32'(s_count), 32'd0);

        // Fill: 18 accepted, 18 and 19 dropped, drain returns 0..17.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, WD'(i), 1'b0);
            if (i == 18) begin
                chk("fill_full", 32'(s_full), 32'd1);
                chk("fill_count", 32'(s_count), 32'd18);
            end
            if (i == 19) chk("fill_ovf_18", 32'(s_ovf), 32'd1);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("fill_ovf_19", 32'(s_ovf), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("fill_ovf_clear", 32'(s_ovf), 32'd0);
        popped.delete();
        for (int i = 0; i < 24; i++) step(1'b0, 8'h00, 1'b1);
        chk("fill_drain_n", 32'(popped.size()), 32'd18);
        for (int i = 0; i < popped.size() && i < 18; i++) chk("fill_drain_data", 32'(popped[i]), 32'(i));

        // Streaming: push and pop every cycle, pointers wrap several times.
        do_reset();
        popped.delete();
        for (int c = 0; c < 100; c++) begin
            step(1'b1, WD'(c + 8'h40), 1'b1);
            if (c >= 3) chk("stream_valid", 32'(s_valid), 32'd1);
            chk("stream_count_bound", 32'(s_count <= 3), 32'd1);
        end
        chk("stream_pop_n", 32'(popped.size()), 32'd97);
        exp_v = 8'h40;
        for (int i = 0; i < popped.size(); i++) begin
            chk("stream_order", 32'(popped[i]), 32'(exp_v));
            exp_v = exp_v + 8'd1;
        end

        // Underflow on empty.
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("udf_pulse", 32'(s_udf), 32'd1);
        chk("udf_count", 32'(s_count), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("udf_clear", 32'(s_udf), 32'd0);

        // Full with simultaneous pop.
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b1, WD'(i + 8'h80), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        popped.delete();
        step(1'b1, 8'hEE, 1'b1);
        chk("fp_full", 32'(s_full), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("fp_ovf", 32'(s_ovf), 32'd1);
        chk("fp_count", 32'(s_count), 32'd17);
        chk("fp_pop_data", 32'(popped.size() == 1 && popped[0] == 8'h80), 32'd1);

        // Reset while a RAM read is in flight; stale return data must vanish.
        do_reset();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        do_reset();
        popped.delete();
        step(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        chk("mid_rst_pop_n", 32'(popped.size()), 32'd1);
        chk("mid_rst_first", 32'(popped.size() > 0 ? popped[0] : 8'h00), 32'h3C);

        // Randomized traffic with shifting push/pop biases.
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            pct_wr = $urandom_range(20, 95);
            pct_rd = $urandom_range(20, 95);
            for (int c = 0; c < 80; c++) begin
                ok = ($urandom_range(0, 99) < pct_wr);
                step(ok, WD'($urandom), $urandom_range(0, 99) < pct_rd);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
